// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_pkg
//  Description : Shared types and constants for the PS/2 host transmitter
//                and its neighbouring receiver.
//  Revision    : 1.0  initial release
// ============================================================================
package ps2_pkg;

    // Transmitter sequencing states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_REQ       = 3'd2,
        ST_WAIT_BITS = 3'd3,
        ST_WAIT_IDLE = 3'd4,
        ST_DONE      = 3'd5,
        ST_ERR       = 3'd6
    } ps2_tx_state_t;

    // Host-to-mouse commands
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_SET_RATE = 8'hF3;

    // Mouse acknowledge byte
    localparam logic [7:0] RSP_ACK      = 8'hFA;

    // PS/2 frames carry odd parity over the eight data bits
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_host_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_host_tx_if
//  Description : Command handshake plus raw PS/2 pin signals of the host
//                transmitter. slave = transmitter, master = user/bus side.
//  Revision    : 1.0  initial release
// ============================================================================
interface ps2_host_tx_if;

    logic [7:0] Tx_Data;
    logic       Tx_Valid;
    logic       Tx_Ready;
    logic       Tx_Done;
    logic       Tx_Err;
    logic       Rx_Inhibit;
    logic       M_CLK_in;
    logic       M_Dat_in;
    logic       M_CLK_oe;
    logic       M_Dat_oe;

    modport master (
        output Tx_Data, Tx_Valid, M_CLK_in, M_Dat_in,
        input  Tx_Ready, Tx_Done, Tx_Err, Rx_Inhibit, M_CLK_oe, M_Dat_oe
    );

    modport slave (
        input  Tx_Data, Tx_Valid, M_CLK_in, M_Dat_in,
        output Tx_Ready, Tx_Done, Tx_Err, Rx_Inhibit, M_CLK_oe, M_Dat_oe
    );

endinterface
`default_nettype wire

// File: rtl/ps2_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_sync_edge
//  Description : Two-flop synchronizers for the PS/2 clock and data pins and
//                a falling-edge detector on the synchronized clock.
//  Revision    : 1.0  initial release
// ============================================================================
module ps2_sync_edge (
    input  wire logic Clk,
    input  wire logic Rst_n,
    input  wire logic i_clk_pin,
    input  wire logic i_dat_pin,
    output logic      o_clk_sync,
    output logic      o_dat_sync,
    output logic      o_clk_fall
);

    logic r_clk_ff1;
    logic r_clk_ff2;
    logic r_clk_prev;
    logic r_dat_ff1;
    logic r_dat_ff2;

    // Synchronizer chains; reset to the idle (released, high) bus level so
    // leaving reset never looks like a clock fall
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_clk_ff1  <= 1'b1;
            r_clk_ff2  <= 1'b1;
            r_clk_prev <= 1'b1;
            r_dat_ff1  <= 1'b1;
            r_dat_ff2  <= 1'b1;
        end else begin
            r_clk_ff1  <= i_clk_pin;
            r_clk_ff2  <= r_clk_ff1;
            r_clk_prev <= r_clk_ff2;
            r_dat_ff1  <= i_dat_pin;
            r_dat_ff2  <= r_dat_ff1;
        end
    end

    assign o_clk_sync = r_clk_ff2;
    assign o_dat_sync = r_dat_ff2;
    assign o_clk_fall = r_clk_prev & ~r_clk_ff2;

endmodule
`default_nettype wire

// File: rtl/ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_host_tx
//  Description : PS/2 host-to-device transmitter. Inhibits the bus, issues a
//                request-to-send, shifts out data/parity/stop on device clock
//                falls and checks the device acknowledge.
//  Revision    : 1.0  initial release
// ============================================================================
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  wire logic      Clk,
    input  wire logic      Rst_n,
    ps2_host_tx_if.slave   bus
);

    localparam int IW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IW-1:0] c_INH_LAST = IW'(INHIBIT_CYCLES - 1);
    localparam logic [TW-1:0] c_TO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    ps2_tx_state_t r_state;
    logic [7:0]    r_shift;
    logic          r_parity;
    logic [IW-1:0] r_inh_cnt;
    logic [TW-1:0] r_to_cnt;
    logic [3:0]    r_bit_cnt;
    logic          r_ready;
    logic          r_done;
    logic          r_err;
    logic          r_rx_inhibit;
    logic          r_clk_oe;
    logic          r_dat_oe;

    logic          w_clk_sync;
    logic          w_dat_sync;
    logic          w_clk_fall;
    logic [3:0]    w_bit_next;
    logic          w_timeout;

    ps2_sync_edge u_sync (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .i_clk_pin  (bus.M_CLK_in),
        .i_dat_pin  (bus.M_Dat_in),
        .o_clk_sync (w_clk_sync),
        .o_dat_sync (w_dat_sync),
        .o_clk_fall (w_clk_fall)
    );

    // Bit counter saturates rather than wrapping
    assign w_bit_next = (r_bit_cnt == 4'hF) ? 4'hF : r_bit_cnt + 4'd1;
    assign w_timeout  = (r_to_cnt == c_TO_LAST);

    // Transmit sequencer with all outputs registered alongside the state
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state      <= ST_IDLE;
            r_shift      <= '0;
            r_parity     <= 1'b0;
            r_inh_cnt    <= '0;
            r_to_cnt     <= '0;
            r_bit_cnt    <= '0;
            r_ready      <= 1'b1;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_rx_inhibit <= 1'b0;
            r_clk_oe     <= 1'b0;
            r_dat_oe     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (bus.Tx_Valid && r_ready) begin
                        r_state      <= ST_INHIBIT;
                        r_shift      <= bus.Tx_Data;
                        r_parity     <= odd_parity(bus.Tx_Data);
                        r_inh_cnt    <= '0;
                        r_clk_oe     <= 1'b1;
                        r_ready      <= 1'b0;
                        r_rx_inhibit <= 1'b1;
                    end
                end
                ST_INHIBIT: begin
                    if (r_inh_cnt == c_INH_LAST) begin
                        r_state  <= ST_REQ;
                        r_dat_oe <= 1'b1;
                    end else begin
                        r_inh_cnt <= r_inh_cnt + 1'b1;
                    end
                end
                ST_REQ: begin
                    // Start bit stays on data while the clock is handed back
                    r_state   <= ST_WAIT_BITS;
                    r_clk_oe  <= 1'b0;
                    r_to_cnt  <= '0;
                    r_bit_cnt <= '0;
                end
                ST_WAIT_BITS: begin
                    if (w_timeout) begin
                        r_state  <= ST_ERR;
                        r_err    <= 1'b1;
                        r_ready  <= 1'b1;
                        r_clk_oe <= 1'b0;
                        r_dat_oe <= 1'b0;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                        if (w_clk_fall) begin
                            r_bit_cnt <= w_bit_next;
                            if (w_bit_next <= 4'd8) begin
                                r_dat_oe <= ~r_shift[0];
                                r_shift  <= {1'b0, r_shift[7:1]};
                            end else if (w_bit_next == 4'd9) begin
                                r_dat_oe <= ~r_parity;
                            end else if (w_bit_next == 4'd10) begin
                                r_dat_oe <= 1'b0;
                            end else if (w_dat_sync) begin
                                // Device left data high: NACK
                                r_state  <= ST_ERR;
                                r_err    <= 1'b1;
                                r_ready  <= 1'b1;
                                r_clk_oe <= 1'b0;
                                r_dat_oe <= 1'b0;
                            end else begin
                                r_state <= ST_WAIT_IDLE;
                            end
                        end
                    end
                end
                ST_WAIT_IDLE: begin
                    if (w_timeout) begin
                        r_state  <= ST_ERR;
                        r_err    <= 1'b1;
                        r_ready  <= 1'b1;
                        r_clk_oe <= 1'b0;
                        r_dat_oe <= 1'b0;
                    end else if (w_clk_sync && w_dat_sync) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                        r_ready <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                ST_DONE, ST_ERR: begin
                    r_state      <= ST_IDLE;
                    r_rx_inhibit <= 1'b0;
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_ready      <= 1'b1;
                    r_rx_inhibit <= 1'b0;
                    r_clk_oe     <= 1'b0;
                    r_dat_oe     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Tx_Ready   = r_ready;
    assign bus.Tx_Done    = r_done;
    assign bus.Tx_Err     = r_err;
    assign bus.Rx_Inhibit = r_rx_inhibit;
    assign bus.M_CLK_oe   = r_clk_oe;
    assign bus.M_Dat_oe   = r_dat_oe;

endmodule
`default_nettype wire

// File: tb/tb_ps2_host_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_host_tx
//  Description : Self-checking bench for ps2_host_tx with an open-drain bus
//                and a scaled-down PS/2 device model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH = 20;
    localparam int TO  = 2000;
    localparam int H   = 20;   // device clock half period in Clk cycles

    localparam logic [1:0] M_ACK    = 2'd0;
    localparam logic [1:0] M_NACK   = 2'd1;
    localparam logic [1:0] M_SILENT = 2'd2;

    typedef struct {
        logic [7:0] data;
        logic [1:0] mode;
        logic [9:0] exp_frame;   // {stop, parity, data} as seen by the device
        logic       exp_done;
        logic       exp_err;
    } vec_t;

    logic Clk = 1'b0;
    logic Rst_n = 1'b0;
    logic dev_clk_low = 1'b0;
    logic dev_dat_low = 1'b0;
    int   n_vec = 0;
    int   n_fail = 0;
    int   done_cnt = 0;
    int   err_cnt = 0;

    ps2_host_tx_if bus ();

    // Open-drain wired-AND of host and device
    assign bus.M_CLK_in = ~bus.M_CLK_oe & ~dev_clk_low;
    assign bus.M_Dat_in = ~bus.M_Dat_oe & ~dev_dat_low;

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus.slave)
    );

    always #5 Clk = ~Clk;

    always @(negedge Clk) begin
        if (bus.Tx_Done) done_cnt++;
        if (bus.Tx_Err)  err_cnt++;
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Present a byte and wait until the DUT takes it; returns at the
    // negedge of the first cycle after the accept edge
    task automatic accept(input logic [7:0] d);
        int n = 0;
        bus.Tx_Data  = d;
        bus.Tx_Valid = 1'b1;
        do begin
            @(negedge Clk);
            n++;
        end while (bus.Tx_Ready && n < 100);
        check("accept", bus.Tx_Ready, 0);
    endtask

    // Inhibit length, request cycle, clock release and start bit
    task automatic req_phase();
        int n = 0;
        while (bus.M_CLK_oe && !bus.M_Dat_oe && n < INH + 10) begin
            n++;
            @(negedge Clk);
        end
        check("inhibit_len", n, INH);
        check("req_both_low", {bus.M_CLK_oe, bus.M_Dat_oe}, 2'b11);
        @(negedge Clk);
        check("clk_release", {bus.M_CLK_oe, bus.M_Dat_oe}, 2'b01);
        check("start_bit", bus.M_Dat_in, 0);
    endtask

    // Device: nfalls clock pulses, sampling data just before each rise
    task automatic dev_frame(input int nfalls, input bit ack, output logic [9:0] bits);
        bits = '0;
        for (int i = 1; i <= nfalls; i++) begin
            if (i == 11 && ack) dev_dat_low = 1'b1;
            repeat (H) @(negedge Clk);
            dev_clk_low = 1'b1;
            repeat (H) @(negedge Clk);
            if (i <= 10) bits[i-1] = bus.M_Dat_in;
            dev_clk_low = 1'b0;
        end
        repeat (H) @(negedge Clk);
        dev_dat_low = 1'b0;
    endtask

    // Wait for Done/Err; n = cycles from clock release
    task automatic wait_result(output int n);
        n = 0;
        while (!(bus.Tx_Done || bus.Tx_Err) && n < TO + 500) begin
            @(negedge Clk);
            n++;
        end
        check("result_seen", bus.Tx_Done | bus.Tx_Err, 1);
        check("ready_with_result", bus.Tx_Ready, 1);
        check("lines_at_result", {bus.M_CLK_oe, bus.M_Dat_oe}, 2'b00);
    endtask

    task automatic run_vec(input vec_t v);
        int d0 = done_cnt;
        int e0 = err_cnt;
        int n;
        logic [9:0] bits;
        accept(v.data);
        bus.Tx_Valid = 1'b0;
        req_phase();
        if (v.mode == M_SILENT) begin
            wait_result(n);
            check("timeout_len", n, TO);
        end else begin
            fork
                dev_frame(11, v.mode == M_ACK, bits);
                wait_result(n);
            join
            check("frame_bits", bits, v.exp_frame);
        end
        repeat (3) @(negedge Clk);
        check("done_pulses", done_cnt - d0, v.exp_done);
        check("err_pulses", err_cnt - e0, v.exp_err);
        check("idle_after", {bus.Tx_Ready, bus.Rx_Inhibit, bus.M_CLK_oe, bus.M_Dat_oe}, 4'b1000);
    endtask

    vec_t vecs[5];

    initial begin
        logic [9:0] bits;
        int n;
        int d0;

        vecs[0] = '{CMD_ENABLE,   M_ACK,    10'h2F4, 1'b1, 1'b0};
        vecs[1] = '{CMD_RESET,    M_ACK,    10'h3FF, 1'b1, 1'b0};
        vecs[2] = '{CMD_SET_RATE, M_ACK,    10'h3F3, 1'b1, 1'b0};
        vecs[3] = '{RSP_ACK,      M_NACK,   10'h3FA, 1'b0, 1'b1};
        vecs[4] = '{CMD_ENABLE,   M_SILENT, 10'h000, 1'b0, 1'b1};

        bus.Tx_Data  = 8'h00;
        bus.Tx_Valid = 1'b0;

        // Reset values
        repeat (3) @(negedge Clk);
        check("reset_outputs",
              {bus.Tx_Ready, bus.Tx_Done, bus.Tx_Err, bus.Rx_Inhibit, bus.M_CLK_oe, bus.M_Dat_oe},
              6'b100000);
        Rst_n = 1'b1;
        repeat (3) @(negedge Clk);

        // Clock falls while idle are ignored
        dev_frame(2, 1'b0, bits);
        check("idle_falls_ignored",
              {bus.Tx_Ready, bus.Rx_Inhibit, bus.M_CLK_oe, bus.M_Dat_oe, bus.Tx_Err}, 5'b10000);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset during inhibit releases the clock line immediately
        accept(CMD_ENABLE);
        bus.Tx_Valid = 1'b0;
        repeat (3) @(negedge Clk);
        #2 Rst_n = 1'b0;
        #1 check("rst_in_inhibit", {bus.M_CLK_oe, bus.M_Dat_oe, bus.Tx_Ready}, 3'b001);
        @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);

        // Reset mid-frame, after the fourth data bit is on the line
        accept(CMD_ENABLE);
        bus.Tx_Valid = 1'b0;
        req_phase();
        dev_frame(4, 1'b0, bits);
        check("mid_frame_dat_oe", bus.M_Dat_oe, 1);
        #2 Rst_n = 1'b0;
        #1 check("rst_mid_frame",
                 {bus.M_CLK_oe, bus.M_Dat_oe, bus.Rx_Inhibit, bus.Tx_Ready}, 4'b0001);
        @(negedge Clk);
        Rst_n = 1'b1;
        @(negedge Clk);
        run_vec(vecs[0]);

        // Tx_Valid held with 0x00 across a 0xF4 transfer
        d0 = done_cnt;
        accept(CMD_ENABLE);
        bus.Tx_Data = 8'h00;
        req_phase();
        fork
            dev_frame(11, 1'b1, bits);
            wait_result(n);
        join
        check("b2b_first_frame", bits, 10'h2F4);
        check("b2b_first_done", bus.Tx_Done, 1);
        @(negedge Clk);
        check("b2b_not_taken_in_done", {bus.Tx_Ready, bus.Tx_Done}, 2'b10);
        @(negedge Clk);
        check("b2b_accept_next", bus.Tx_Ready, 0);
        bus.Tx_Valid = 1'b0;
        req_phase();
        fork
            dev_frame(11, 1'b1, bits);
            wait_result(n);
        join
        check("b2b_second_frame", bits, 10'h300);
        repeat (3) @(negedge Clk);
        check("b2b_done_pulses", done_cnt - d0, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
